// File: rtl/seven_seg_scan_driver_if.sv
// Display-side bundle: digit data and masks in, shared segment bus and anodes out.
`timescale 1ns/1ps
interface seven_seg_scan_driver_if;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (output en, digits, dp_mask, blink_mask, input an, seg, dp);
    modport slave  (input en, digits, dp_mask, blink_mask, output an, seg, dp);
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver with per-digit decimal point and blink.
`timescale 1ns/1ps
module seven_seg_scan_driver #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    seven_seg_scan_driver_if.slave  bus
);
    localparam int unsigned DIV_W   = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
    logic [1:0]         digit_idx_q, digit_idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic       tick;
    logic       lit;
    logic [3:0] nibble;

    // Active-low {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // Everything, including the lit digit, advances only on the scan tick.
    always_comb begin
        tick          = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
        div_cnt_d     = tick ? '0 : div_cnt_q + DIV_W'(1);
        digit_idx_d   = digit_idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        an_d          = an_q;
        seg_d         = seg_q;
        dp_d          = dp_q;
        lit           = 1'b0;
        nibble        = 4'd0;

        if (tick) begin
            digit_idx_d = digit_idx_q + 2'd1;
            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end

            // Anode, segments and dp are loaded together so no stale digit ghosts.
            lit    = bus.en & ~(blink_phase_q & bus.blink_mask[digit_idx_q]);
            nibble = bus.digits[{digit_idx_q, 2'b00} +: 4];
            if (lit) begin
                an_d  = ~(4'b0001 << digit_idx_q);
                seg_d = decode(nibble);
                dp_d  = ~bus.dp_mask[digit_idx_q];
            end else begin
                an_d  = 4'b1111;
                seg_d = 7'h7F;
                dp_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            digit_idx_q   <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            div_cnt_q     <= div_cnt_d;
            digit_idx_q   <= digit_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: directed scenarios plus randomized run against a tick-count model.
`timescale 1ns/1ps
module tb_seven_seg_scan_driver;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    seven_seg_scan_driver_if bus_if ();

    seven_seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Model: count edges since reset; every SCAN_DIV-th edge is the k-th tick,
    // which shows digit (k-1)%4 with blink phase ((k-1)/BLINK_DIV)%2.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    int         n = 0;
    logic [3:0] exp_an  = 4'hF;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp  = 1'b1;

    always @(posedge clk) begin
        int   k, idx, ph;
        logic lit;
        if (rst) begin
            n = 0; exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            n = n + 1;
            if (n % SCAN_DIV == 0) begin
                k   = n / SCAN_DIV;
                idx = (k - 1) % 4;
                ph  = ((k - 1) / BLINK_DIV) % 2;
                lit = bus_if.en && !(ph == 1 && bus_if.blink_mask[idx]);
                if (lit) begin
                    exp_an  = 4'hF & ~(4'(1) << idx);
                    exp_seg = seg_tab[(bus_if.digits >> (4 * idx)) & 16'hF];
                    exp_dp  = ~bus_if.dp_mask[idx];
                end else begin
                    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; bus_if.en = 1'b0; bus_if.digits = 16'h0;
        bus_if.dp_mask = 4'h0; bus_if.blink_mask = 4'h0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus_if.an !== 4'hF || bus_if.seg !== 7'h7F || bus_if.dp !== 1'b1) begin
            n_err++; $display("FAIL reset_state: an=%b seg=%h dp=%b want 1111/7f/1", bus_if.an, bus_if.seg, bus_if.dp);
        end
        rst = 1'b0; bus_if.digits = 16'h1234; bus_if.en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); n_cmp++;
            if (bus_if.an !== 4'hF || bus_if.seg !== 7'h7F) begin
                n_err++; $display("FAIL dark_before_tick c%0d: an=%b seg=%h want 1111/7f", c, bus_if.an, bus_if.seg);
            end
        end
        @(negedge clk); n_cmp++;
        if (bus_if.an !== 4'b1110 || bus_if.seg !== 7'h19) begin
            n_err++; $display("FAIL first_digit: an=%b seg=%h want 1110/19", bus_if.an, bus_if.seg);
        end
    endtask

    task automatic test_scan();
        logic [3:0] ea [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        logic [6:0] es [4] = '{7'h30, 7'h24, 7'h79, 7'h19};
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk); n_cmp++;
                if (bus_if.an !== exp_an || bus_if.seg !== exp_seg || bus_if.dp !== exp_dp) begin
                    n_err++; $display("FAIL scan_model s%0d c%0d: an=%b seg=%h dp=%b want %b/%h/%b", s, c, bus_if.an, bus_if.seg, bus_if.dp, exp_an, exp_seg, exp_dp);
                end
            end
            n_cmp++;
            if (bus_if.an !== ea[s] || bus_if.seg !== es[s]) begin
                n_err++; $display("FAIL scan_slot s%0d: an=%b seg=%h want %b/%h", s, bus_if.an, bus_if.seg, ea[s], es[s]);
            end
        end
    endtask

    task automatic test_dp();
        int lows = 0;
        bus_if.dp_mask = 4'b0100;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); n_cmp++;
            if (bus_if.dp !== exp_dp || bus_if.an !== exp_an) begin
                n_err++; $display("FAIL dp_model c%0d: an=%b dp=%b want %b/%b", c, bus_if.an, bus_if.dp, exp_an, exp_dp);
            end
            if (bus_if.dp === 1'b0) begin
                lows++; n_cmp++;
                if (bus_if.an !== 4'b1011) begin
                    n_err++; $display("FAIL dp_wrong_digit: an=%b want 1011 while dp=0", bus_if.an);
                end
            end
        end
        n_cmp++;
        if (lows != 4) begin
            n_err++; $display("FAIL dp_low_cycles: got %0d want 4", lows);
        end
        bus_if.dp_mask = 4'b0000;
    endtask

    task automatic test_blink();
        int lit_cycles = 0;
        bus_if.blink_mask = 4'b1111;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk); n_cmp++;
            if (bus_if.an !== exp_an || bus_if.seg !== exp_seg) begin
                n_err++; $display("FAIL blink_model c%0d: an=%b seg=%h want %b/%h", c, bus_if.an, bus_if.seg, exp_an, exp_seg);
            end
            if (bus_if.an !== 4'hF) lit_cycles++;
        end
        n_cmp++;
        if (lit_cycles != 16) begin
            n_err++; $display("FAIL blink_duty: lit %0d of 32 want 16", lit_cycles);
        end
        bus_if.blink_mask = 4'b0000;
    endtask

    task automatic test_illegal_bcd();
        logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] es [4] = '{7'h10, 7'h3F, 7'h40, 7'h3F};
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus_if.digits = 16'hF0A9;
        for (int s = 0; s < 4; s++) begin
            repeat (4) @(negedge clk);
            n_cmp++;
            if (bus_if.an !== ea[s] || bus_if.seg !== es[s]) begin
                n_err++; $display("FAIL illegal_bcd s%0d: an=%b seg=%h want %b/%h", s, bus_if.an, bus_if.seg, ea[s], es[s]);
            end
        end
    endtask

    task automatic test_mid_change();
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus_if.digits = 16'h1234;
        repeat (5) @(negedge clk);
        bus_if.digits = 16'h5678;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); n_cmp++;
            if (bus_if.an !== 4'b1110 || bus_if.seg !== 7'h19) begin
                n_err++; $display("FAIL mid_change_hold c%0d: an=%b seg=%h want 1110/19", c, bus_if.an, bus_if.seg);
            end
        end
        @(negedge clk); n_cmp++;
        if (bus_if.an !== 4'b1101 || bus_if.seg !== 7'h78) begin
            n_err++; $display("FAIL mid_change_next: an=%b seg=%h want 1101/78", bus_if.an, bus_if.seg);
        end
    endtask

    task automatic test_enable();
        @(negedge clk);
        bus_if.en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); n_cmp++;
            if (bus_if.an !== 4'b1101) begin
                n_err++; $display("FAIL en_off_hold c%0d: an=%b want 1101", c, bus_if.an);
            end
        end
        for (int c = 0; c < 9; c++) begin
            @(negedge clk); n_cmp++;
            if (bus_if.an !== 4'hF || bus_if.seg !== 7'h7F || bus_if.dp !== 1'b1) begin
                n_err++; $display("FAIL en_off_dark c%0d: an=%b seg=%h dp=%b want 1111/7f/1", c, bus_if.an, bus_if.seg, bus_if.dp);
            end
        end
        bus_if.en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); n_cmp++;
            if (bus_if.an !== exp_an || bus_if.seg !== exp_seg) begin
                n_err++; $display("FAIL en_on_model c%0d: an=%b seg=%h want %b/%h", c, bus_if.an, bus_if.seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_mid_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); n_cmp++;
        if (bus_if.an !== 4'hF || bus_if.seg !== 7'h7F || bus_if.dp !== 1'b1) begin
            n_err++; $display("FAIL mid_reset_dark: an=%b seg=%h dp=%b want 1111/7f/1", bus_if.an, bus_if.seg, bus_if.dp);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus_if.an !== 4'b1110 || bus_if.seg !== 7'h00) begin
            n_err++; $display("FAIL mid_reset_restart: an=%b seg=%h want 1110/00", bus_if.an, bus_if.seg);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk); n_cmp++;
            if (bus_if.an !== exp_an || bus_if.seg !== exp_seg || bus_if.dp !== exp_dp) begin
                n_err++; $display("FAIL random_model c%0d: an=%b seg=%h dp=%b want %b/%h/%b", c, bus_if.an, bus_if.seg, bus_if.dp, exp_an, exp_seg, exp_dp);
            end
            n_cmp++;
            if ($countones(~bus_if.an) > 1) begin
                n_err++; $display("FAIL random_onehot c%0d: an=%b want at most one low", c, bus_if.an);
            end
            if ($urandom_range(0, 5) == 0) begin
                bus_if.digits     = 16'($urandom);
                bus_if.dp_mask    = 4'($urandom);
                bus_if.blink_mask = 4'($urandom);
            end
            bus_if.en = ($urandom_range(0, 9) != 0);
            rst       = ($urandom_range(0, 149) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_dp();
        test_blink();
        test_illegal_bcd();
        test_mid_change();
        test_enable();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
